// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares one synchronous-read boot ROM between a CPU port (A) and a loader port (B)
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_a_req / i_a_addr        port A read request and address
//   o_a_ack                   port A accepted this cycle (combinational)
//   o_a_valid / o_a_data      port A read data strobe (registered) and data
//   i_b_* / o_b_*             same as port A, for port B
//   o_rom_addr                address presented to the ROM (captured on the rising edge)
//   i_rom_data                ROM read data, valid the cycle after the address is captured
//   o_last_grant              observation of the last-grant register (0 = A, 1 = B)
//
// Build option:
//   BOOTROM_ARB_RR_EN         defined: round-robin on ties; undefined: A always wins ties
module bootrom_arbiter #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic              o_a_ack,
    output logic              o_a_valid,
    output logic [7:0]        o_a_data,
    input  logic              i_b_req,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic              o_b_ack,
    output logic              o_b_valid,
    output logic [7:0]        o_b_data,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic              o_last_grant
);
    logic r_a_pend;
    logic r_b_pend;
    logic r_last_grant;
    logic w_a_req;
    logic w_b_req;
    logic w_tie_to_b;
    logic w_a_gnt;
    logic w_b_gnt;

    // Requests are masked while reset is held so no ack or address leaks out.
    assign w_a_req = i_a_req & i_rst_n;
    assign w_b_req = i_b_req & i_rst_n;

`ifdef BOOTROM_ARB_RR_EN
    // On a tie, favour whichever port did not win last time.
    assign w_tie_to_b = ~r_last_grant;
`else
    assign w_tie_to_b = 1'b0;
`endif

    assign w_a_gnt = w_a_req & ~(w_b_req & w_tie_to_b);
    assign w_b_gnt = w_b_req & ~w_a_gnt;

    assign o_a_ack      = w_a_gnt;
    assign o_b_ack      = w_b_gnt;
    assign o_rom_addr   = w_a_gnt ? i_a_addr : w_b_gnt ? i_b_addr : '0;
    assign o_a_valid    = r_a_pend;
    assign o_b_valid    = r_b_pend;
    assign o_a_data     = i_rom_data;
    assign o_b_data     = i_rom_data;
    assign o_last_grant = r_last_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_pend     <= 1'b0;
            r_b_pend     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_a_pend <= w_a_gnt;
            r_b_pend <= w_b_gnt;
            // Idle or withdrawn cycles leave the history untouched.
            if (w_a_gnt | w_b_gnt)
                r_last_grant <= w_b_gnt;
        end
    end
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: directed bench with a per-cycle behavioural model of the arbiter and ROM
module tb_bootrom_arbiter;
    localparam int AW = 13;
`ifdef BOOTROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic          a_ack, b_ack, a_valid, b_valid, last_grant;
    logic [7:0]    a_data, b_data, rom_data;
    logic [AW-1:0] rom_addr, rom_q;
    logic [7:0]    mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bootrom_arbiter #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_addr(a_addr), .o_a_ack(a_ack), .o_a_valid(a_valid), .o_a_data(a_data),
        .i_b_req(b_req), .i_b_addr(b_addr), .o_b_ack(b_ack), .o_b_valid(b_valid), .o_b_data(b_data),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_last_grant(last_grant)
    );

    // Boot ROM: registered address, data out the following cycle.
    always_ff @(posedge clk) rom_q <= rom_addr;
    assign rom_data = mem[rom_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: who wins this cycle from the rules, what comes back the next cycle.
    logic          m_va = 1'b0, m_vb = 1'b0, m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    initial begin
        int w;
        logic [AW-1:0] w_addr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_va = 1'b0; m_vb = 1'b0; m_last = 1'b1;
            end
            if (!rst_n) w = 0;
            else if (a_req && b_req) w = (RR && !m_last) ? 2 : 1;
            else if (a_req) w = 1;
            else if (b_req) w = 2;
            else w = 0;
            w_addr = (w == 1) ? a_addr : (w == 2) ? b_addr : '0;
            chk("m_a_ack", 32'(a_ack), 32'(w == 1));
            chk("m_b_ack", 32'(b_ack), 32'(w == 2));
            chk("m_rom_addr", 32'(rom_addr), 32'(w_addr));
            chk("m_a_valid", 32'(a_valid), 32'(m_va));
            chk("m_b_valid", 32'(b_valid), 32'(m_vb));
            chk("m_last_grant", 32'(last_grant), 32'(m_last));
            if (m_va) chk("m_a_data", 32'(a_data), 32'(mem[m_addr]));
            if (m_vb) chk("m_b_data", 32'(b_data), 32'(mem[m_addr]));
            @(posedge clk);
            if (!rst_n) begin
                m_va = 1'b0; m_vb = 1'b0; m_last = 1'b1;
            end else begin
                m_va = (w == 1);
                m_vb = (w == 2);
                m_addr = w_addr;
                if (w != 0) m_last = (w == 2);
            end
        end
    end

    initial begin
        int na, nb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'((i * 37) ^ (i >> 5));
        mem[13'h0010] = 8'hA5;
        mem[13'h1FFE] = 8'h5C;
        mem[13'h1FFF] = 8'hC3;

        // Reset held with both requests up.
        a_req = 1'b1; b_req = 1'b1; a_addr = 13'h0123; b_addr = 13'h0456;
        repeat (2) step();
        @(negedge clk);
        chk("rst_a_ack", 32'(a_ack), 0);
        chk("rst_b_ack", 32'(b_ack), 0);
        chk("rst_valids", 32'({a_valid, b_valid}), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_last", 32'(last_grant), 1);

        // Single port A read.
        step();
        rst_n = 1'b1; b_req = 1'b0; a_addr = 13'h0010;
        @(negedge clk);
        chk("a1_ack", 32'(a_ack), 1);
        chk("a1_rom_addr", 32'(rom_addr), 32'h10);
        step();
        a_req = 1'b0;
        @(negedge clk);
        chk("a1_valid", 32'(a_valid), 1);
        chk("a1_data", 32'(a_data), 32'hA5);
        chk("a1_b_valid", 32'(b_valid), 0);

        // Back-to-back port B at the top of the address space.
        step();
        b_req = 1'b1; b_addr = 13'h1FFE;
        @(negedge clk);
        chk("b2_ack0", 32'(b_ack), 1);
        step();
        b_addr = 13'h1FFF;
        @(negedge clk);
        chk("b2_ack1", 32'(b_ack), 1);
        chk("b2_valid0", 32'(b_valid), 1);
        chk("b2_data0", 32'(b_data), 32'h5C);
        step();
        b_req = 1'b0;
        @(negedge clk);
        chk("b2_valid1", 32'(b_valid), 1);
        chk("b2_data1", 32'(b_data), 32'hC3);
        step();

        // Contention straight after a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; a_req = 1'b1; b_req = 1'b1; a_addr = 13'h0100; b_addr = 13'h0200;
        na = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_a_ack", 32'(a_ack), RR ? 32'((i % 2) == 0) : 1);
            chk("cont_b_ack", 32'(b_ack), RR ? 32'((i % 2) == 1) : 0);
            if (i > 0) begin na += int'(a_valid); nb += int'(b_valid); end
            step();
        end
        a_req = 1'b0;
        @(negedge clk);
        na += int'(a_valid); nb += int'(b_valid);
        chk("cont_a_valids", 32'(na), RR ? 3 : 6);
        chk("cont_b_valids", 32'(nb), RR ? 3 : 0);
        chk("cont_b_after_drop", 32'(b_ack), 1);
        step();
        b_req = 1'b0;
        step();

        // Withdrawn request: last grant is B, both ask, A wins, B gives up.
        a_req = 1'b1; b_req = 1'b1; a_addr = 13'h0777; b_addr = 13'h0888;
        @(negedge clk);
        chk("wd_a_ack", 32'(a_ack), 1);
        chk("wd_b_ack", 32'(b_ack), 0);
        step();
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("wd_last", 32'(last_grant), 0);
        chk("wd_b_valid", 32'(b_valid), 0);
        step();
        @(negedge clk);
        chk("wd_b_valid2", 32'(b_valid), 0);
        chk("wd_last2", 32'(last_grant), 0);

        // Reset asserted while an A access is in flight.
        step();
        a_req = 1'b1; a_addr = 13'h0010;
        @(negedge clk);
        chk("mr_ack", 32'(a_ack), 1);
        step();
        a_req = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("mr_valid_drop", 32'(a_valid), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_after_valids", 32'({a_valid, b_valid}), 0);
        step();
        @(negedge clk);
        chk("mr_after_valids2", 32'({a_valid, b_valid}), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bootrom_arbiter.md
# bootrom_arbiter

Shares the single synchronous-read boot ROM between two requesters: port A (CPU instruction/data fetch) and port B (boot-time loader that copies ROM into RAM). It grants at most one ROM access per cycle and drives the ROM address. It returns ROM data to the winning port with a one-cycle-later valid strobe, matching the ROM's registered-address read latency. It sits between the CPU bus decode, the loader, and the boot ROM instance.

## Interface
- ADDR_W, 13, ROM address width in bits; must match the boot ROM's ADDR_W.

- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_req  input  1  port A read request; held high until a_ack is seen
- a_addr  input  ADDR_W  port A read address; stable while a_req is high
- a_ack  output  1  port A request accepted this cycle (combinational)
- a_valid  output  1  a_data holds port A read data this cycle (registered)
- a_data  output  8  port A read data
- b_req, b_addr, b_ack, b_valid, b_data: same as the port A signals, for port B
- rom_addr  output  ADDR_W  address to the ROM; the ROM captures it on the rising edge
- rom_data  input  8  ROM read data, valid the cycle after rom_addr is captured

## Operation
- Grant decision is combinational each cycle from a_req, b_req and the last_grant register.
  - Only one requester active: it is granted.
  - Both active: the arbitration policy decides (see Configuration).
  - Neither active: no grant.
- Granted port: its x_ack is 1 this cycle and rom_addr = its x_addr. With no grant, rom_addr = 0 and both acks are 0.
- At most one ack per cycle, never both.
- Requester protocol:
  - On seeing x_ack high at the clock edge, the requester may drop x_req or present a new address with x_req still high.
  - Back-to-back grants to the same port are allowed: one access per cycle.
- Registered state:
  - a_pend, b_pend: set to the ack value at each edge; they drive a_valid and b_valid.
  - last_grant: updated only on cycles with a grant; 0 = A, 1 = B.
- Data return: a_data = b_data = rom_data (passthrough). Data is meaningful only when the matching x_valid is 1.
- Reset (rst_n low, asynchronous):
  - a_valid = b_valid = 0 immediately; last_grant = 1 (B), so A wins the first tie.
  - a_ack = b_ack = 0 and rom_addr = 0 while rst_n is low.
  - An access in flight when reset asserts is discarded; no valid is produced for it after release.

## Timing
- Cycle N: x_req high and granted, so x_ack = 1 and rom_addr = x_addr.
- Edge ending N: the ROM registers the address; x_pend <= 1.
- Cycle N+1: x_valid = 1 and x_data = mem[x_addr]. Latency from ack to data is 1 cycle.
- Sustained rate is one access per cycle in total across both ports.
- Simultaneous a_valid and b_valid cannot occur.
- A requester dropping x_req in the same cycle its ack would have come gets nothing. No grant is recorded and last_grant is unchanged.
- rst_n deassertion is synchronized externally. The first grant can occur in the first cycle after release.

## Configuration
- BOOTROM_ARB_RR_EN defined: round-robin. On a tie, grant the port not recorded in last_grant, so each port waits at most 1 cycle under contention.
- BOOTROM_ARB_RR_EN undefined: fixed priority, A always wins ties. last_grant is still maintained but ignored, and B can be starved indefinitely.

## Test plan
- Reset: hold rst_n = 0 with a_req = b_req = 1 -> a_ack = b_ack = 0, a_valid = b_valid = 0, rom_addr = 0. Assert rst_n low mid-access -> a_valid drops at once, and no valid appears after release.
- Single port A read: ROM preloaded mem[0x0010] = 0xA5; a_req = 1, a_addr = 0x0010 in cycle N -> a_ack = 1 in N, a_valid = 1 with a_data = 0xA5 in N+1, b_valid = 0 throughout.
- Back-to-back port B: b_req held high, b_addr = 0x1FFE then 0x1FFF -> b_ack high 2 consecutive cycles, then b_valid high 2 consecutive cycles returning mem[0x1FFE] and mem[0x1FFF].
- Contention with BOOTROM_ARB_RR_EN: both requests held high for 6 cycles after reset -> grants A, B, A, B, A, B, each port getting 3 valids with correct data.
- Contention without BOOTROM_ARB_RR_EN: both requests held high 6 cycles -> 6 A grants, b_ack = 0 throughout. After a_req drops, B is granted in the next cycle.
- Request withdrawn: b_req high for 1 cycle while A is granted, then low -> no b_ack, no b_valid, and last_grant remains A.
